// File: rtl/datapath_pkg.sv
// Shared widths and constants for the shift-add multiplier datapath.
package datapath_pkg;
  localparam int OPERAND_W = 32;
  localparam int PRODUCT_W = 64;
  localparam int CNT_W     = 6;
  localparam logic [CNT_W-1:0] CNT_INIT = 6'd32;
endpackage

// File: rtl/datapath_adder32.sv
// Unsigned 32-bit adder with carry-out used for the accumulate step.
module adder32
  import datapath_pkg::*;
(
  input  logic [OPERAND_W-1:0] a,
  input  logic [OPERAND_W-1:0] b,
  output logic [OPERAND_W-1:0] sum,
  output logic                 cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/datapath.sv
// 32x32 unsigned shift-add multiplier datapath; all sequencing comes from an
// external controller through the control inputs.
module datapath
  import datapath_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPERAND_W-1:0] multiplicant,
  input  logic [OPERAND_W-1:0] multiplier,
  input  logic                 init,
  input  logic                 l_lsb,
  input  logic                 shift_load,
  input  logic                 lsb_select,
  input  logic                 cycle_finish,
  output logic [PRODUCT_W-1:0] res,
  output logic                 i_eq_0
);

  logic [OPERAND_W-1:0] mcand_q, mcand_d;
  logic [PRODUCT_W-1:0] prod_q, prod_d;
  logic                 carry_q, carry_d;
  logic                 lsb_q, lsb_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 add_bit;
  logic [OPERAND_W-1:0] sum;
  logic                 sum_cout;

  assign add_bit = lsb_select ? prod_q[0] : lsb_q;

  adder32 u_adder32 (
    .a    (prod_q[PRODUCT_W-1:OPERAND_W]),
    .b    (mcand_q),
    .sum  (sum),
    .cout (sum_cout)
  );

  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    carry_d = carry_q;
    lsb_d   = lsb_q;
    cnt_d   = cnt_q;
    if (init) begin
      mcand_d = multiplicant;
      prod_d  = {{OPERAND_W{1'b0}}, multiplier};
      carry_d = 1'b0;
      lsb_d   = 1'b0;
      cnt_d   = CNT_INIT;
    end else if (l_lsb) begin
      lsb_d = prod_q[0];
    end else if (!shift_load) begin
      // Carry from the preceding add becomes the new product MSB.
      prod_d  = {carry_q, prod_q[PRODUCT_W-1:1]};
      carry_d = 1'b0;
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end else if (cycle_finish && add_bit) begin
      prod_d  = {sum, prod_q[OPERAND_W-1:0]};
      carry_d = sum_cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      prod_q  <= '0;
      carry_q <= 1'b0;
      lsb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      carry_q <= carry_d;
      lsb_q   <= lsb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign res    = prod_q;
  assign i_eq_0 = (cnt_q == '0);

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed scenarios plus randomized operands
// compared against an arithmetic model of the partial product.
module tb_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] multiplicant, multiplier;
  logic        init, l_lsb, shift_load, lsb_select, cycle_finish;
  logic [63:0] res;
  logic        i_eq_0;

  int errs   = 0;
  int checks = 0;

  datapath dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .multiplicant (multiplicant),
    .multiplier   (multiplier),
    .init         (init),
    .l_lsb        (l_lsb),
    .shift_load   (shift_load),
    .lsb_select   (lsb_select),
    .cycle_finish (cycle_finish),
    .res          (res),
    .i_eq_0       (i_eq_0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // After k iterations: low k bits of the multiplier consumed into the
  // accumulator, remaining multiplier bits sit right-aligned below it.
  function automatic logic [63:0] partial(input logic [31:0] a, input logic [31:0] b, input int k);
    logic [63:0] mb, p;
    mb = (k >= 32) ? {32'h0, b} : ({32'h0, b} & ((64'd1 << k) - 64'd1));
    p  = {32'h0, a} * mb;
    return (p << (32 - k)) | ({32'h0, b} >> k);
  endfunction

  task automatic cyc(input bit i, input bit l, input bit sl, input bit ls, input bit cf);
    init = i; l_lsb = l; shift_load = sl; lsb_select = ls; cycle_finish = cf;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] b);
    multiplicant = a;
    multiplier   = b;
    cyc(1, 0, 0, 0, 0);
  endtask

  task automatic iterate(input bit lsel, input bit use_l);
    if (use_l) cyc(0, 1, 1'($urandom_range(1)), lsel, 1'($urandom_range(1)));
    cyc(0, 0, 1, lsel, 1);
    cyc(0, 0, 0, lsel, 1'($urandom_range(1)));
  endtask

  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          input bit lsel, input bit use_l, input bit track);
    load(a, b);
    chk("load_res", res, {32'h0, b});
    chk("load_ieq", {63'h0, i_eq_0}, 64'h0);
    for (int k = 1; k <= 32; k++) begin
      iterate(lsel, use_l);
      if (track) chk("partial", res, partial(a, b, k));
      if (k == 31) chk("ieq_before_last", {63'h0, i_eq_0}, 64'h0);
    end
    chk("product", res, {32'h0, a} * {32'h0, b});
    chk("ieq_done", {63'h0, i_eq_0}, 64'h1);
  endtask

  initial begin
    logic [63:0] exp_r;
    logic [31:0] ra, rb;
    bit          rl, ru;

    rst_n = 1'b0;
    multiplicant = '0; multiplier = '0;
    init = 0; l_lsb = 0; shift_load = 1; lsb_select = 0; cycle_finish = 0;
    #12;
    chk("reset_res", res, 64'h0);
    chk("reset_ieq", {63'h0, i_eq_0}, 64'h1);
    rst_n = 1'b1;

    run_mult(32'd3, 32'd2, 0, 1, 1);
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 1);
    chk("ffff_exact", res, 64'hFFFF_FFFE_0000_0001);

    // Shifts past cnt==0 keep shifting the product, counter stays at zero.
    exp_r = res;
    for (int s = 0; s < 3; s++) begin
      cyc(0, 0, 0, 0, 0);
      exp_r = exp_r >> 1;
      chk("post_zero_shift", res, exp_r);
      chk("post_zero_ieq", {63'h0, i_eq_0}, 64'h1);
    end

    // init beats l_lsb: set lsb_q=1 first, then init+l_lsb must clear it.
    load(32'd9, 32'd3);
    cyc(0, 1, 1, 0, 0);
    multiplicant = 32'd9; multiplier = 32'd6;
    cyc(1, 1, 1, 0, 1);
    chk("init_wins_res", res, 64'd6);
    cyc(0, 0, 1, 0, 1);
    chk("init_wins_lsbq", res, 64'd6);
    cyc(1, 1, 0, 0, 0);
    for (int k = 1; k <= 32; k++) begin
      iterate(0, 1);
      if (k == 31) chk("init_wins_cnt31", {63'h0, i_eq_0}, 64'h0);
    end
    chk("init_wins_prod", res, 64'd54);
    chk("init_wins_ieq", {63'h0, i_eq_0}, 64'h1);

    // cycle_finish=0 with shift_load=1 holds, whatever add_bit would be.
    load(32'd5, 32'd7);
    for (int s = 0; s < 4; s++) cyc(0, 0, 1, s[0], 0);
    chk("hold_res", res, 64'h0000_0000_0000_0007);
    chk("hold_ieq", {63'h0, i_eq_0}, 64'h0);

    run_mult(32'd5, 32'd7, 1, 0, 1);
    chk("lsel1_35", res, 64'd35);

    // Asynchronous reset between edges during iteration 10.
    load(32'h1234_5678, 32'h9ABC_DEF1);
    for (int k = 1; k <= 9; k++) iterate(0, 1);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_res", res, 64'h0);
    chk("async_rst_ieq", {63'h0, i_eq_0}, 64'h1);
    #1 rst_n = 1'b1;
    for (int s = 0; s < 3; s++) cyc(0, 0, 1, 0, 0);
    chk("post_rst_res", res, 64'h0);
    chk("post_rst_ieq", {63'h0, i_eq_0}, 64'h1);

    for (int t = 0; t < 20; t++) begin
      ra = $urandom;
      rb = $urandom;
      ru = 1'($urandom_range(1));
      rl = ru ? 1'($urandom_range(1)) : 1'b1;
      run_mult(ra, rb, rl, ru, (t % 4) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The block SHALL be a 32x32 unsigned shift-add multiplier datapath; the external controller drives all control inputs.
REQ-002 clk  input  1  single clock, all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 multiplicant  input  32  multiplicand operand, sampled only when init=1.
REQ-005 multiplier  input  32  multiplier operand, sampled only when init=1.
REQ-006 init  input  1  load operands and restart the iteration counter.
REQ-007 l_lsb  input  1  latch the current product LSB into the decision flag.
REQ-008 shift_load  input  1  0 = shift step, 1 = add/hold step.
REQ-009 lsb_select  input  1  add-decision source: 0 = latched flag lsb_q, 1 = live prod[0].
REQ-010 cycle_finish  input  1  enables the conditional add write when shift_load=1.
REQ-011 res  output  64  current product register, driven directly from the register, no extra latency.
REQ-012 i_eq_0  output  1  combinational, high when the iteration counter equals 0.

Function
REQ-013 Internal state SHALL be:
- mcand[31:0]
- prod[63:0] (upper half is the accumulator, lower half is the multiplier)
- carry (1 bit, adder carry-out)
- lsb_q (1 bit)
- cnt[5:0]
REQ-014 add_bit SHALL equal prod[0] when lsb_select=1, else lsb_q.
REQ-015 Each rising edge SHALL perform exactly one action, by priority:
- init
- l_lsb
- shift (shift_load=0)
- add (shift_load=1 and cycle_finish=1)
- hold
REQ-016 init=1: mcand<=multiplicant, prod<={32'h0, multiplier}, carry<=0, lsb_q<=0, cnt<=32.
REQ-017 l_lsb=1 (init=0): lsb_q<=prod[0]; all other state holds.
REQ-018 Shift (init=0, l_lsb=0, shift_load=0):
- prod<={carry, prod[63:1]}, carry<=0.
- cnt<=cnt-1 when cnt!=0, else holds at 0.
- cycle_finish is ignored.
REQ-019 Add (init=0, l_lsb=0, shift_load=1, cycle_finish=1):
- if add_bit=1: {carry, prod[63:32]} <= prod[63:32] + mcand (33-bit sum); prod[31:0] holds.
- if add_bit=0: all state holds.
REQ-020 shift_load=1 with cycle_finish=0 (and init=0, l_lsb=0) SHALL hold all state.
REQ-021 The correct multiply sequence SHALL be:
- init
- then 32 iterations of {l_lsb; add; shift}
- afterwards res = multiplicant*multiplier (full 64-bit result, no overflow) and i_eq_0=1.
REQ-022 Shifts performed after cnt reaches 0 SHALL still shift prod, and cnt SHALL stay 0.
REQ-023 The add carry-out SHALL be retained and shifted into prod[63], so the 33-bit sum is never lost.

Reset
REQ-024 rst_n=0 SHALL asynchronously clear mcand, prod, carry, lsb_q and cnt to 0, giving res=0 and i_eq_0=1.
REQ-025 Reset asserted mid-operation SHALL abort the multiply; after release, no update occurs until the next control input.

Structure
REQ-026 A shared package SHALL hold OPERAND_W=32, PRODUCT_W=64 and CNT_INIT=32.
REQ-027 The 33-bit add SHALL be one sub-module, adder32 (two 32-bit inputs; 32-bit sum plus carry-out).
REQ-028 The block SHALL contain no FSM; sequencing belongs to the controller.

Verification
REQ-029 Scenario: init with 3 and 2, then 32x{l_lsb, add with lsb_select=0, shift} -> res=64'd6; i_eq_0 rises exactly after the 32nd shift.
REQ-030 Scenario: 0xFFFFFFFF x 0xFFFFFFFF through the full sequence -> res=64'hFFFFFFFE_00000001 (exercises carry).
REQ-031 Scenario: init and l_lsb high together -> init wins, lsb_q=0, cnt=32, res={32'h0, multiplier}.
REQ-032 Scenario: shift_load=1 and cycle_finish=0 for several cycles after init with 5 and 7 -> res stays 64'h0000_0000_0000_0007.
REQ-033 Scenario: rst_n pulsed low between clock edges during iteration 10 -> res=0 and i_eq_0=1 immediately, without waiting for a clock edge.
REQ-034 Scenario: with lsb_select=1 and l_lsb never asserted, 5 x 7 -> res=64'd35.
